pipeline_stage_register: RTL and testbench
==========================================

Name: pipeline_stage_register

Overview:
- Parametrised, handshaked successor to the fixed EX/MEM pipeline register.
- One generic stage carries a control bundle and a data bundle between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready flow control, a cache-hit stall, flush/bubble insertion, an optional 2-entry skid buffer and a saturating stall counter.
- Instanced once per stage boundary in the pipelined core.

Parameters:
- CTRL_WIDTH, 5, width of the control bundle (RegWrite, MemToReg, Branch, MemRead, MemWrite, ...); cleared on a bubble.
- DATA_WIDTH, 101, width of the data bundle (add_result, read_data_2, Zero, ALU_result, write_register_index, ...); never cleared.
- SKID, 1, 1 = 2-entry skid buffer so that in_ready is a pure register output; 0 = single entry with combinational in_ready.
- COUNT_WIDTH, 16, width of the stall counter.

Ports:
- clock, input, 1, rising-edge clock.
- reset_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, upstream has a valid instruction.
- in_ready, output, 1, stage can accept this cycle.
- in_ctrl, input, CTRL_WIDTH, incoming control bits.
- in_data, input, DATA_WIDTH, incoming data bits.
- out_valid, output, 1, stage holds a valid instruction.
- out_ready, input, 1, downstream accepts.
- out_ctrl, output, CTRL_WIDTH, registered control (zero when out_valid=0).
- out_data, output, DATA_WIDTH, registered data.
- hit, input, 1, cache hit; 0 = memory stall, stage must hold.
- flush, input, 1, squash all held entries (branch taken).
- stall_count, output, COUNT_WIDTH, saturating count of stalled cycles.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - out_valid=0, out_ctrl=0, skid empty, state EMPTY, stall_count=0, in_ready=1 on the next cycle.
  - out_data is unspecified (don't care).
  - Reset mid-transfer discards all entries.
- Definitions:
  - advance = out_valid & out_ready & hit.
  - accept = in_valid & in_ready.
- Registered outputs: all outputs are registers except in_ready when SKID=0, where in_ready = ~out_valid | (out_ready & hit).
- State machine (SKID=1). States: EMPTY, FULL (main register only), SKID (main and skid registers both occupied).
  - EMPTY: accept -> FULL; main register loads in_*.
  - FULL, accept & advance: stay in FULL; main register loads in_*.
  - FULL, accept & ~advance: -> SKID; skid register loads in_*.
  - FULL, ~accept & advance: -> EMPTY.
  - FULL, otherwise: hold.
  - SKID, advance: -> FULL; main register loads skid contents; in_ready=0 during this cycle.
  - SKID, otherwise: hold.
  - in_ready = (state != SKID), registered.
- Latency: one cycle from accept to out_valid when the stage is empty.
- Ordering: strict FIFO; no drop or duplication under any out_ready/hit pattern.
- Stall (hit=0): behaves exactly as out_ready=0. out_* stay stable and the held contents do not change.
- Flush (flush=1 at a clock edge):
  - Next state EMPTY; out_valid=0; out_ctrl=0; skid cleared.
  - Any same-cycle accept is dropped.
  - Flush has priority over accept, advance and stall.
  - Flush and reset asserted together: reset wins, which also clears stall_count.
- Bubble rule: whenever out_valid=0, out_ctrl must be 0, so no spurious RegWrite or MemWrite reaches the next stage.
- stall_count:
  - Increments by 1 each cycle with out_valid=1 and hit=0.
  - Saturates at 2^COUNT_WIDTH-1; does not wrap.
  - Cleared only by reset; flush does not clear it.
- SKID=0: single entry.
  - State is EMPTY or FULL; the SKID state is unreachable.
  - The main register loads on accept. Accept and advance in the same cycle is a pass-through update.

Decomposition:
- Shared package pipeline_pkg:
  - Stage-state enum {EMPTY, FULL, SKID}.
  - Per-stage CTRL_WIDTH/DATA_WIDTH constants (e.g. EX_MEM_CTRL_WIDTH=5, EX_MEM_DATA_WIDTH=101).
  - Field offset constants for packing and unpacking the bundles.
- One sub-module: stage_entry_register, a single ctrl+data register with load, clear-ctrl and hold controls, instanced as the main register and (when SKID=1) the skid register.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with in_valid=1 and in_ctrl=5'b11111 -> out_valid=0, out_ctrl=0, stall_count=0 and in_ready=1 after release.
- Pass-through: in_valid=1, out_ready=1, hit=1; send ALU_result 333, 334 and 335 on consecutive cycles -> the same values appear one cycle later, back to back, with no bubbles.
- Cache stall: FULL holding 111; then hit=0 for 3 cycles while in_valid=1 carries 222 -> state SKID, in_ready=0, out_data stays 111, stall_count=3. After hit=1: 111 then 222 are delivered in order.
- Flush in SKID: flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the input carried in the flush cycle never appears; stall_count is unchanged.
- Saturation: COUNT_WIDTH=4, hold hit=0 for 20 cycles with out_valid=1 -> stall_count stops at 15.
- Randomised backpressure: random out_ready/hit, 1000 transactions, run for both SKID=0 and SKID=1 -> a scoreboard sees an exact in-order match, and out_ctrl=0 on every cycle where out_valid=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared stage-state enum, per-stage bundle widths and field offsets
package pipeline_pkg;

    // Occupancy of one stage boundary: nothing, main register only, main plus skid
    typedef enum logic [1:0] {
        STAGE_EMPTY = 2'd0,
        STAGE_FULL  = 2'd1,
        STAGE_SKID  = 2'd2
    } stage_state_t;

    // Control bundle bit positions (shared by every stage that carries them)
    localparam int CTRL_REG_WRITE_BIT  = 0;
    localparam int CTRL_MEM_TO_REG_BIT = 1;
    localparam int CTRL_BRANCH_BIT     = 2;
    localparam int CTRL_MEM_READ_BIT   = 3;
    localparam int CTRL_MEM_WRITE_BIT  = 4;

    // Per-boundary bundle widths
    localparam int IF_ID_CTRL_WIDTH   = 1;
    localparam int IF_ID_DATA_WIDTH   = 64;
    localparam int ID_EX_CTRL_WIDTH   = 9;
    localparam int ID_EX_DATA_WIDTH   = 140;
    localparam int EX_MEM_CTRL_WIDTH  = 5;
    localparam int EX_MEM_DATA_WIDTH  = 101;
    localparam int MEM_WB_CTRL_WIDTH  = 2;
    localparam int MEM_WB_DATA_WIDTH  = 68;

    // EX/MEM data bundle layout
    localparam int WORD_WIDTH                 = 32;
    localparam int REG_INDEX_WIDTH            = 4;
    localparam int EX_MEM_ALU_RESULT_LSB      = 0;
    localparam int EX_MEM_READ_DATA_2_LSB     = 32;
    localparam int EX_MEM_ADD_RESULT_LSB      = 64;
    localparam int EX_MEM_ZERO_BIT            = 96;
    localparam int EX_MEM_WRITE_REG_INDEX_LSB = 97;

    // Extract the ALU result field from a packed EX/MEM data bundle
    function automatic logic [WORD_WIDTH-1:0] ex_mem_alu_result(
        input logic [EX_MEM_DATA_WIDTH-1:0] data
    );
        return data[EX_MEM_ALU_RESULT_LSB +: WORD_WIDTH];
    endfunction

endpackage

// File: rtl/stage_entry_register.sv
// rtl/stage_entry_register.sv - one ctrl+data holding register with load and ctrl clear
module stage_entry_register #(
    parameter int CTRL_WIDTH = 5,
    parameter int DATA_WIDTH = 101
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  clear,
    input  logic [CTRL_WIDTH-1:0] d_ctrl,
    input  logic [DATA_WIDTH-1:0] d_data,
    output logic [CTRL_WIDTH-1:0] q_ctrl,
    output logic [DATA_WIDTH-1:0] q_data
);

    // Control bits: cleared on reset or bubble (clear beats load), otherwise load or hold
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q_ctrl <= '0;
        end else if (clear) begin
            q_ctrl <= '0;
        end else if (load) begin
            q_ctrl <= d_ctrl;
        end
    end

    // Data bits are never cleared; a bubble only needs harmless control
    always_ff @(posedge clock) begin
        if (load) begin
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipeline_stage_register.sv
// rtl/pipeline_stage_register.sv - handshaked pipeline stage register with skid buffer and stall counter
module pipeline_stage_register
    import pipeline_pkg::*;
#(
    parameter int CTRL_WIDTH  = EX_MEM_CTRL_WIDTH,
    parameter int DATA_WIDTH  = EX_MEM_DATA_WIDTH,
    parameter int SKID        = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_WIDTH-1:0]  in_ctrl,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_WIDTH-1:0]  out_ctrl,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   hit,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    stage_state_t          state;
    stage_state_t          state_next;
    logic                  in_ready_r;
    logic                  advance;
    logic                  accept;
    logic                  main_load;
    logic                  main_from_skid;
    logic                  main_clear;
    logic                  skid_load;
    logic                  skid_clear;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] main_d_ctrl;
    logic [DATA_WIDTH-1:0] main_d_data;

    // A cache miss freezes the stage exactly like downstream backpressure
    assign advance  = out_valid & out_ready & hit;
    assign accept   = in_valid & in_ready;
    assign in_ready = (SKID != 0) ? in_ready_r : (~out_valid | (out_ready & hit));

    // Next occupancy and register load strobes; flush overrides everything else
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            STAGE_EMPTY: begin
                if (accept) begin
                    state_next = STAGE_FULL;
                    main_load  = 1'b1;
                end
            end
            STAGE_FULL: begin
                if (accept && advance) begin
                    main_load = 1'b1;
                end else if (accept && SKID != 0) begin
                    state_next = STAGE_SKID;
                    skid_load  = 1'b1;
                end else if (advance) begin
                    state_next = STAGE_EMPTY;
                end
            end
            STAGE_SKID: begin
                if (advance) begin
                    state_next     = STAGE_FULL;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = STAGE_EMPTY;
        endcase
        if (flush) begin
            state_next     = STAGE_EMPTY;
            main_load      = 1'b0;
            main_from_skid = 1'b0;
            skid_load      = 1'b0;
        end
    end

    // An entry that will not hold a valid instruction next cycle gets zero control
    assign main_clear  = (state_next == STAGE_EMPTY);
    assign skid_clear  = (state_next != STAGE_SKID);
    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    stage_entry_register #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_main (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (main_load),
        .clear   (main_clear),
        .d_ctrl  (main_d_ctrl),
        .d_data  (main_d_data),
        .q_ctrl  (out_ctrl),
        .q_data  (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            stage_entry_register #(
                .CTRL_WIDTH (CTRL_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_skid (
                .clock   (clock),
                .reset_n (reset_n),
                .load    (skid_load),
                .clear   (skid_clear),
                .d_ctrl  (in_ctrl),
                .d_data  (in_data),
                .q_ctrl  (skid_ctrl),
                .q_data  (skid_data)
            );
        end else begin : g_no_skid
            assign skid_ctrl = '0;
            assign skid_data = '0;
        end
    endgenerate

    // State plus registered out_valid / in_ready, both decoded from the next state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= STAGE_EMPTY;
            out_valid  <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            state      <= state_next;
            out_valid  <= (state_next != STAGE_EMPTY);
            in_ready_r <= (state_next != STAGE_SKID);
        end
    end

    // Saturating count of cycles spent holding a valid instruction through a miss
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (out_valid && !hit && (stall_count != {COUNT_WIDTH{1'b1}})) begin
            stall_count <= stall_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stage_register.sv
// tb/tb_pipeline_stage_register.sv - randomized scoreboard bench for pipeline_stage_register
module tb_pipeline_stage_register;
    import pipeline_pkg::*;

    localparam int CW = EX_MEM_CTRL_WIDTH;
    localparam int DW = EX_MEM_DATA_WIDTH;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          hit;
    logic          flush;

    logic          s1_in_ready, s1_out_valid;
    logic [CW-1:0] s1_out_ctrl;
    logic [DW-1:0] s1_out_data;
    logic [3:0]    s1_stall;
    logic          s0_in_ready, s0_out_valid;
    logic [CW-1:0] s0_out_ctrl;
    logic [DW-1:0] s0_out_data;
    logic [15:0]   s0_stall;

    bit            sel;
    logic          obs_in_ready, obs_out_valid;
    logic [CW-1:0] obs_out_ctrl;
    logic [DW-1:0] obs_out_data;
    logic [15:0]   obs_stall;

    logic [CW+DW-1:0] q[$];
    int unsigned      m_stall;
    int               n_out;
    int               n_checks;
    int               n_errors;

    always #5 clock = ~clock;

    pipeline_stage_register #(.SKID(1), .COUNT_WIDTH(4)) dut_skid (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s1_out_valid), .out_ready(out_ready),
        .out_ctrl(s1_out_ctrl), .out_data(s1_out_data), .hit(hit), .flush(flush),
        .stall_count(s1_stall)
    );

    pipeline_stage_register #(.SKID(0), .COUNT_WIDTH(16)) dut_single (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s0_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s0_out_valid), .out_ready(out_ready),
        .out_ctrl(s0_out_ctrl), .out_data(s0_out_data), .hit(hit), .flush(flush),
        .stall_count(s0_stall)
    );

    always_comb begin
        obs_in_ready  = sel ? s1_in_ready  : s0_in_ready;
        obs_out_valid = sel ? s1_out_valid : s0_out_valid;
        obs_out_ctrl  = sel ? s1_out_ctrl  : s0_out_ctrl;
        obs_out_data  = sel ? s1_out_data  : s0_out_data;
        obs_stall     = sel ? {12'd0, s1_stall} : s0_stall;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (skid=%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [31:0] v);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r[EX_MEM_ALU_RESULT_LSB +: WORD_WIDTH] = v;
        return r[DW-1:0];
    endfunction

    // One cycle: drive inputs, compare outputs with the occupancy model, advance the model
    task automatic step(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                        input logic ordy, input logic h, input logic fl);
        logic        exp_ready;
        logic        acc;
        logic        adv;
        int unsigned m_max;
        @(negedge clock);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        hit       = h;
        flush     = fl;
        #1;
        m_max     = sel ? 32'd15 : 32'd65535;
        exp_ready = sel ? (q.size() < 2) : ((q.size() == 0) || (ordy && h));
        check_eq("in_ready", obs_in_ready, exp_ready);
        check_eq("out_valid", obs_out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("out_ctrl", obs_out_ctrl, q[0][CW+DW-1:DW]);
            check_eq("out_data", obs_out_data, q[0][DW-1:0]);
        end else begin
            check_eq("bubble_ctrl", obs_out_ctrl, '0);
        end
        check_eq("stall_count", obs_stall, m_stall);
        acc = iv && exp_ready;
        adv = (q.size() != 0) && ordy && h;
        if ((q.size() != 0) && !h && (m_stall < m_max)) m_stall++;
        if (fl) begin
            q.delete();
        end else begin
            if (adv) begin
                void'(q.pop_front());
                n_out++;
            end
            if (acc) q.push_back({ic, id});
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = '1;
        in_data   = '1;
        out_ready = 1'b1;
        hit       = 1'b1;
        flush     = 1'b0;
        repeat (2) @(negedge clock);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        q.delete();
        m_stall = 0;
    endtask

    task automatic run_random(input int n_want);
        int           n_start;
        int           cyc;
        logic [127:0] r;
        n_start = n_out;
        cyc     = 0;
        while ((n_out - n_start < n_want) && (cyc < 8000)) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            step($urandom_range(3, 0) != 0, CW'($urandom), r[DW-1:0],
                 $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
                 $urandom_range(63, 0) == 0);
            cyc++;
        end
        check_eq("random_done", (n_out - n_start) >= n_want, 1'b1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_out     = 0;
        m_stall   = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        hit       = 1'b1;
        flush     = 1'b0;
        sel       = 1'b1;

        do_reset();
        // back-to-back pass-through
        step(1'b1, 5'b00011, mk_data(333), 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'b00011, mk_data(334), 1'b1, 1'b1, 1'b0);
        check_eq("pt_333", ex_mem_alu_result(obs_out_data), 32'd333);
        step(1'b1, 5'b00011, mk_data(335), 1'b1, 1'b1, 1'b0);
        check_eq("pt_334", ex_mem_alu_result(obs_out_data), 32'd334);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        check_eq("pt_335", ex_mem_alu_result(obs_out_data), 32'd335);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

        // cache stall fills the skid register
        step(1'b1, 5'b01001, mk_data(111), 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'b10010, mk_data(222), 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'b10010, mk_data(222), 1'b1, 1'b0, 1'b0);
        check_eq("stall_in_ready", obs_in_ready, 1'b0);
        step(1'b1, 5'b10010, mk_data(222), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        check_eq("stall_cnt3", obs_stall, 16'd3);
        check_eq("stall_hold_111", ex_mem_alu_result(obs_out_data), 32'd111);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        check_eq("stall_then_222", ex_mem_alu_result(obs_out_data), 32'd222);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

        // flush while both entries are occupied
        step(1'b1, 5'b11111, mk_data(444), 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'b11111, mk_data(555), 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'b11111, mk_data(666), 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        check_eq("flush_valid", obs_out_valid, 1'b0);
        check_eq("flush_ctrl", obs_out_ctrl, '0);
        check_eq("flush_stall_kept", obs_stall, 16'd3);

        // flush drops a same-cycle accept
        step(1'b1, 5'b11111, mk_data(777), 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'b11111, mk_data(888), 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        check_eq("flush_drop_valid", obs_out_valid, 1'b0);

        // saturation of the 4-bit counter
        step(1'b1, 5'b00001, mk_data(999), 1'b1, 1'b1, 1'b0);
        repeat (20) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("stall_saturate", obs_stall, 16'd15);

        run_random(1000);

        sel = 1'b0;
        do_reset();
        run_random(1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
